// File: rtl/alu_md_seq.sv
// alu_md_seq: registered ALU with iterative multiply/divide behind a valid/ready handshake
module alu_md_seq #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_LSB = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_ALUctrl,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_Zero
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_MUL = 4'b0011;
  localparam logic [3:0] OP_MULHU = 4'b0100, OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001, OP_SRA = 4'b1010, OP_SRL = 4'b1011, OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101, OP_REMU = 4'b1110;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH:0]   hi, hi_n, sum, r, diff;
  logic [WIDTH-1:0] lo, lo_n, d, alu_y, md_y;
  logic [SW-1:0]    shamt;
  logic             accept, is_md, is_mul, q_is_mul;
  assign o_ready  = (state == IDLE) || (state == DONE && i_ready);
  assign accept   = i_valid && o_ready && !i_flush;
  assign shamt    = i_B[SHAMT_LSB +: SW];
  assign is_mul   = (i_ALUctrl == OP_MUL) || (i_ALUctrl == OP_MULHU);
  assign is_md    = is_mul || (i_ALUctrl == OP_DIVU) || (i_ALUctrl == OP_REMU);
  assign q_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
  always_comb begin
    case (i_ALUctrl)
      OP_AND:  alu_y = i_A & i_B;
      OP_OR:   alu_y = i_A | i_B;
      OP_XOR:  alu_y = i_A ^ i_B;
      OP_ADD:  alu_y = i_A + i_B;
      OP_SUB:  alu_y = i_A - i_B;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(i_A) < $signed(i_B)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, i_A < i_B};
      OP_SLL:  alu_y = i_A << shamt;
      OP_SRL:  alu_y = i_A >> shamt;
      OP_SRA:  alu_y = $signed(i_A) >>> shamt;
      default: alu_y = '0;
    endcase
  end
  // hi:lo is the product for multiply, remainder:quotient-shift for divide
  always_comb begin
    sum  = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, d} : '0);
    r    = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff = r - {1'b0, d};
    hi_n = q_is_mul ? {1'b0, sum[WIDTH:1]} : (diff[WIDTH] ? r : diff);
    lo_n = q_is_mul ? {sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~diff[WIDTH]};
    md_y = (op_q == OP_MULHU || op_q == OP_REMU) ? hi_n[WIDTH-1:0] : lo_n;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_Y     <= '0;
      o_Zero  <= 1'b1;
      cnt     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      d       <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_Y     <= md_y;
            o_Zero  <= (md_y == '0);
          end
        end
        default: begin
          if (accept && is_md) begin
            state   <= BUSY;
            o_valid <= 1'b0;
            cnt     <= CW'(WIDTH);
            op_q    <= i_ALUctrl;
            hi      <= '0;
            lo      <= is_mul ? i_B : i_A;
            d       <= is_mul ? i_A : i_B;
          end else if (accept) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_Y     <= alu_y;
            o_Zero  <= (alu_y == '0);
          end else if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md_seq.sv
// tb_alu_md_seq: directed vector table plus hand sequences for hold, flush and reset
module tb_alu_md_seq;
  localparam int W = 32;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, MUL = 4'b0011;
  localparam logic [3:0] MULHU = 4'b0100, SUB = 4'b0110, SLT = 4'b0111, SLTU = 4'b1000;
  localparam logic [3:0] SLL = 4'b1001, SRA = 4'b1010, SRL = 4'b1011, DIVU = 4'b1100;
  localparam logic [3:0] XOR_ = 4'b1101, REMU = 4'b1110, BAD = 4'b1111;
  logic         i_clk = 0, i_rst_n = 0, i_flush = 0, i_valid = 0, i_ready = 0;
  logic [3:0]   i_ALUctrl = '0;
  logic [W-1:0] i_A = '0, i_B = '0;
  logic         o_ready, o_valid, o_Zero;
  logic [W-1:0] o_Y;
  int checks = 0, errors = 0;
  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a, b, y;
    int           lat;
  } vec_t;
  vec_t vt[$];

  alu_md_seq #(.WIDTH(W), .SHAMT_LSB(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_ALUctrl(i_ALUctrl), .i_A(i_A), .i_B(i_B),
    .o_valid(o_valid), .i_ready(i_ready), .o_Y(o_Y), .o_Zero(o_Zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge i_clk);
    i_valid = 1; i_ALUctrl = op; i_A = a; i_B = b;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge i_clk);
      i_valid = 0; i_ready = 0; i_A = '1; i_B = '1;
      lat++;
    end while (!o_valid && lat < 100);
    if (!o_valid) begin
      errors++;
      $display("FAIL timeout waiting for o_valid after %0d cycles", lat);
    end
  endtask

  task automatic run(input vec_t v);
    int lat;
    issue(v.op, v.a, v.b);
    chk({v.name, "_ready"}, {31'b0, o_ready}, 1);
    wait_valid(lat);
    chk({v.name, "_lat"}, lat, v.lat);
    chk({v.name, "_y"}, o_Y, v.y);
    chk({v.name, "_zero"}, {31'b0, o_Zero}, {31'b0, v.y == 0});
    i_ready = 1;
    @(negedge i_clk);
    i_ready = 0;
    chk({v.name, "_drain"}, {31'b0, o_valid}, 0);
  endtask

  initial begin
    int lat, seen;
    vt.push_back('{"add_wrap", ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1});
    vt.push_back('{"slt",      SLT,   32'hFFFFFFFF, 32'h0,        32'h1,        1});
    vt.push_back('{"sltu",     SLTU,  32'hFFFFFFFF, 32'h0,        32'h0,        1});
    vt.push_back('{"sra",      SRA,   32'h80000000, 32'h000000C0, 32'hF0000000, 1});
    vt.push_back('{"sll",      SLL,   32'h80000000, 32'h000000C0, 32'h0,        1});
    vt.push_back('{"srl",      SRL,   32'h80000000, 32'h000000C0, 32'h10000000, 1});
    vt.push_back('{"and",      AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
    vt.push_back('{"or",       OR_,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1});
    vt.push_back('{"xor",      XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
    vt.push_back('{"sub",      SUB,   32'd5,        32'd7,        32'hFFFFFFFE, 1});
    vt.push_back('{"bad_op",   BAD,   32'h12345678, 32'h1,        32'h0,        1});
    vt.push_back('{"mulhu",    MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W + 1});
    vt.push_back('{"mul",      MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        W + 1});
    vt.push_back('{"mul_dec",  MUL,   32'd12345,    32'd1000,     32'd12345000, W + 1});
    vt.push_back('{"divu",     DIVU,  32'd100,      32'd7,        32'd14,       W + 1});
    vt.push_back('{"remu",     REMU,  32'd100,      32'd7,        32'd2,        W + 1});
    vt.push_back('{"divu_big", DIVU,  32'hFFFFFFFF, 32'd10,       32'd429496729, W + 1});
    vt.push_back('{"remu_big", REMU,  32'hFFFFFFFF, 32'd10,       32'd5,        W + 1});
    vt.push_back('{"divu_z",   DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, W + 1});
    vt.push_back('{"remu_z",   REMU,  32'd5,        32'd0,        32'd5,        W + 1});
    #12;
    chk("rst_valid", {31'b0, o_valid}, 0);
    chk("rst_y", o_Y, 0);
    chk("rst_zero", {31'b0, o_Zero}, 1);
    chk("rst_ready", {31'b0, o_ready}, 1);
    @(negedge i_clk);
    i_rst_n = 1;
    foreach (vt[i]) run(vt[i]);
    // result held under back-pressure, then a same-cycle handoff and accept
    issue(ADD, 32'd3, 32'd4);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("hold_y", o_Y, 32'd7);
      chk("hold_valid", {31'b0, o_valid}, 1);
      chk("hold_ready", {31'b0, o_ready}, 0);
    end
    i_ready = 1; i_valid = 1; i_ALUctrl = ADD; i_A = 32'd10; i_B = 32'd20;
    #1 chk("b2b_ready", {31'b0, o_ready}, 1);
    wait_valid(lat);
    chk("b2b_lat", lat, 1);
    chk("b2b_y", o_Y, 32'd30);
    i_ready = 1;
    @(negedge i_clk);
    i_ready = 0;
    // flush mid-divide
    issue(DIVU, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      i_valid = 0;
    end
    chk("flush_busy_ready", {31'b0, o_ready}, 0);
    i_flush = 1;
    @(negedge i_clk);
    i_flush = 0;
    chk("flush_valid", {31'b0, o_valid}, 0);
    chk("flush_ready", {31'b0, o_ready}, 1);
    chk("flush_y_kept", o_Y, 32'd30);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    // request during flush is dropped
    i_flush = 1; i_valid = 1; i_ALUctrl = ADD; i_A = 32'd1; i_B = 32'd1;
    @(negedge i_clk);
    i_flush = 0; i_valid = 0;
    chk("flush_req_valid", {31'b0, o_valid}, 0);
    chk("flush_req_y", o_Y, 32'd30);
    // async reset in the middle of a multiply
    issue(MUL, 32'd3, 32'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_valid = 0;
    end
    #2 i_rst_n = 0;
    #1;
    chk("arst_y", o_Y, 0);
    chk("arst_valid", {31'b0, o_valid}, 0);
    chk("arst_zero", {31'b0, o_Zero}, 1);
    chk("arst_ready", {31'b0, o_ready}, 1);
    @(negedge i_clk);
    i_rst_n = 1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("arst_no_valid", seen, 0);
    run('{"post_rst_add", ADD, 32'd2, 32'd2, 32'd4, 1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
- Parametrised, registered successor to the pipeline's single-cycle ALU.
- Keeps the existing ALU operation encodings and adds iterative multiply/divide: MUL, MULHU, DIVU, REMU.
- Sits in the EX stage behind a valid/ready handshake. The hazard unit stalls the pipe while o_ready is low.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8, power of 2)
SHAMT_LSB, 6, LSB position of the shift-amount field inside i_B; the field is $clog2(WIDTH) bits wide

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous abort of any operation in flight
i_valid  input  1  operation request
o_ready  output  1  block can accept a request this cycle
i_ALUctrl  input  4  operation select
i_A  input  WIDTH  operand A
i_B  input  WIDTH  operand B
o_valid  output  1  o_Y/o_Zero hold a result
i_ready  input  1  consumer accepts the result
o_Y  output  WIDTH  registered result
o_Zero  output  1  registered, (o_Y == 0)

Behaviour:
- Reset (async, i_rst_n low):
  - state=IDLE, o_valid=0, o_Y=0, o_Zero=1, o_ready=1.
  - All iteration registers are cleared.
- Op encodings:
  - Unchanged: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SLL, 1010 SRA, 1011 SRL, 1101 XOR.
  - New: 0011 MUL (low WIDTH bits of A*B), 0100 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1110 REMU.
  - Any other code: result 0, latency 1.
- Shifts use shamt = i_B[SHAMT_LSB +: $clog2(WIDTH)].
- ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU produce 1 or 0, zero-extended.
- Handshake:
  - A request is accepted when i_valid && o_ready.
  - o_ready = (state==IDLE) || (state==DONE && i_ready).
  - This allows back-to-back accepts: a new request accepted in the same cycle as a result handoff.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, single-cycle op accepted: register the result, go to DONE. o_valid=1 on the next cycle (latency 1).
  - IDLE, MD op accepted: latch operands and op, load counter = WIDTH, go to BUSY. o_ready=0.
  - BUSY: one radix-2 step per cycle; counter decrements.
    - Multiply: shift-add over 2*WIDTH product.
    - Divide: restoring shift-subtract.
    - When counter reaches 0, write o_Y, go to DONE. Total latency from accept to o_valid = WIDTH+1 cycles.
  - DONE: o_valid=1. o_Y/o_Zero held stable until i_ready.
    - On i_ready without a new accept: go to IDLE, o_valid=0 next cycle.
    - On i_ready with a new accept: follow the IDLE rules for the new op.
- Divide by zero: DIVU result = all ones; REMU result = i_A. Still takes WIDTH+1 cycles; no special fast path.
- i_flush: from any state, go to IDLE next cycle, o_valid=0, the in-flight result is discarded, o_Y keeps its last value.
  - A request presented with i_flush high is not accepted.
  - i_flush has priority over i_valid and i_ready.
- Operands i_A/i_B/i_ALUctrl are sampled only at accept. Changes during BUSY have no effect.
- o_Zero always equals (o_Y==0) and is updated with o_Y.
- Async reset mid-BUSY: immediate return to reset values; no partial result is exposed.

Test Plan:
- Reset then ADD A=0xFFFFFFFF, B=1 -> o_valid 1 cycle after accept, o_Y=0, o_Zero=1; SLT A=0xFFFFFFFF, B=0 -> o_Y=1.
- SRA A=0x80000000, B=0x000000C0 (shamt=3) -> o_Y=0xF0000000; SLL same operands -> 0x00000000, o_Zero=1.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> o_ready low for 32 cycles, o_valid at cycle 33, o_Y=0xFFFFFFFE; MUL same operands -> 0x00000001.
- DIVU A=100, B=7 -> o_Y=14; REMU -> 2; DIVU A=5, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5.
- Result held with i_ready=0 for 5 cycles -> o_Y stable, o_valid=1, o_ready=0; then i_ready=1 with a new ADD request -> accepted the same cycle, next result one cycle later.
- i_flush asserted at BUSY cycle 10 of a DIVU -> IDLE next cycle, o_valid never asserts; async reset asserted during a MUL -> o_Y=0, o_valid=0 immediately.
